// File: rtl/miniRISC_pkg.sv
// miniRISC_pkg: writeback source encodings shared by the writeback arbiter and its mux.
package miniRISC_pkg;

   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_MEM  = 2'd1;
   localparam logic [1:0] SRC_LINK = 2'd2;
   localparam int         NUM_WB_SRC = 3;

   function automatic logic [1:0] next_src(input logic [1:0] s);
      return (s == SRC_LINK) ? SRC_ALU : s + 2'd1;
   endfunction

endpackage

// File: rtl/mux_32b_3_1.sv
// mux_32b_3_1: 3:1 data mux; select 00 ALU, 01 MEM, 10 LINK (11 falls back to ALU).
module mux_32b_3_1
   import miniRISC_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [1:0]    sel,
   input  logic [DW-1:0] in0,
   input  logic [DW-1:0] in1,
   input  logic [DW-1:0] in2,
   output logic [DW-1:0] out
);

   always_comb begin
      out = (sel == SRC_MEM) ? in1 : (sel == SRC_LINK) ? in2 : in0;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin sharing of the register-file write port between ALU, MEM and LINK.
// Define WB_ARB_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module wb_port_arbiter
   import miniRISC_pkg::*;
#(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      req_valid,
   output logic [2:0]      req_ready,
   input  logic [DW-1:0]   alu_data,
   input  logic [DW-1:0]   mem_data,
   input  logic [DW-1:0]   link_data,
   input  logic [3*AW-1:0] req_rd,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [DW-1:0]   rf_wdata
`ifdef WB_ARB_CONFLICT_CNT_EN
   ,
   output logic [CNT_W-1:0] conflict_cnt
`endif
);

   logic [1:0]    last_grant, sel_q, sel, p0, p1, p2, gidx;
   logic          grant;
   logic [AW-1:0] rd;
   logic [DW-1:0] mux_out;

   // Search starts one past the last winner, so every loser waits at most two cycles.
   always_comb begin
      p0        = next_src(last_grant);
      p1        = next_src(p0);
      p2        = next_src(p1);
      gidx      = req_valid[p0] ? p0 : req_valid[p1] ? p1 : p2;
      grant     = !rst && (|req_valid);
      sel       = grant ? gidx : sel_q;
      req_ready = grant ? (3'b001 << gidx) : 3'b000;
      rd        = (gidx == SRC_MEM)  ? req_rd[AW +: AW] :
                  (gidx == SRC_LINK) ? req_rd[2*AW +: AW] : req_rd[0 +: AW];
   end

   mux_32b_3_1 #(.DW(DW)) u_mux (
      .sel (sel),
      .in0 (alu_data),
      .in1 (mem_data),
      .in2 (link_data),
      .out (mux_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= SRC_LINK;
         sel_q      <= SRC_ALU;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
      end else begin
         sel_q <= sel;
         rf_we <= grant && (rd != '0);
         if (grant) begin
            last_grant <= gidx;
            rf_waddr   <= rd;
            rf_wdata   <= mux_out;
         end
      end
   end

`ifdef WB_ARB_CONFLICT_CNT_EN
   logic multi;

   always_comb begin
      multi = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
              (req_valid[1] & req_valid[2]);
   end

   always_ff @(posedge clk) begin
      if (rst)
         conflict_cnt <= '0;
      else if (multi && !(&conflict_cnt))
         conflict_cnt <= conflict_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized checks of wb_port_arbiter against a round-robin reference model.
module tb_wb_port_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int CNT_W = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      req_valid, req_ready;
   logic [DW-1:0]   alu_data, mem_data, link_data;
   logic [3*AW-1:0] req_rd;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;
`ifdef WB_ARB_CONFLICT_CNT_EN
   logic [CNT_W-1:0] conflict_cnt;
`endif

   wb_port_arbiter #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .alu_data  (alu_data),
      .mem_data  (mem_data),
      .link_data (link_data),
      .req_rd    (req_rd),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata)
`ifdef WB_ARB_CONFLICT_CNT_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int            m_last, m_cnt, grant_idx;
   logic          m_we;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   logic [2:0]    exp_ready, obs_ready;

   // First valid source scanning upward (mod 3) from the one after the last winner.
   function automatic int pick(input logic [2:0] v, input int last);
      for (int k = 1; k <= 3; k++)
         if (v[(last + k) % 3]) return (last + k) % 3;
      return -1;
   endfunction

   function automatic logic [DW-1:0] data_of(input int i);
      return (i == 0) ? alu_data : (i == 1) ? mem_data : link_data;
   endfunction

   function automatic logic [AW-1:0] rd_of(input int i);
      return req_rd[AW*i +: AW];
   endfunction

   task automatic set_src(input int i, input logic [DW-1:0] d, input logic [AW-1:0] r);
      if (i == 0) alu_data = d;
      else if (i == 1) mem_data = d;
      else link_data = d;
      req_rd[AW*i +: AW] = r;
   endtask

   // One clock: sample req_ready mid-cycle, advance the model at the edge, settle 1 time unit.
   task automatic tick;
      @(negedge clk);
      grant_idx = rst ? -1 : pick(req_valid, m_last);
      exp_ready = (grant_idx < 0) ? 3'b000 : 3'(1 << grant_idx);
      obs_ready = req_ready;
      @(posedge clk);
      if (rst) begin
         m_last = 2; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
      end else begin
         m_we = (grant_idx >= 0) && (rd_of(grant_idx) != '0);
         if (grant_idx >= 0) begin
            m_waddr = rd_of(grant_idx);
            m_wdata = data_of(grant_idx);
            m_last  = grant_idx;
         end
         if ($countones(req_valid) >= 2 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 3'b111;
      alu_data = 32'h1111_1111; mem_data = 32'h2222_2222; link_data = 32'h3333_3333;
      req_rd = {5'd3, 5'd2, 5'd1};
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++; if (obs_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b want=000", obs_ready); end
         checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", rf_we); end
         checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d want=0", rf_waddr); end
         checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h want=0", rf_wdata); end
      end
   endtask

   task automatic test_single;
      rst = 1'b0; req_valid = 3'b001; alu_data = 32'h0000_1234; req_rd = {5'd0, 5'd0, 5'd5};
      tick();
      checks++; if (obs_ready !== 3'b001) begin errors++; $display("FAIL single_ready got=%b want=001", obs_ready); end
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we got=%b want=1", rf_we); end
      checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_waddr got=%0d want=5", rf_waddr); end
      checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL single_wdata got=%h want=1234", rf_wdata); end
      req_valid = 3'b000;
   endtask

   task automatic test_conflict;
      logic [2:0]    want_ready [3] = '{3'b001, 3'b010, 3'b100};
      logic [DW-1:0] want_data  [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
      logic [AW-1:0] want_rd    [3] = '{5'd7, 5'd8, 5'd9};
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 3; i++) set_src(i, want_data[i], want_rd[i]);
      req_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (obs_ready !== want_ready[i]) begin errors++; $display("FAIL conflict_ready[%0d] got=%b want=%b", i, obs_ready, want_ready[i]); end
         checks++; if (rf_wdata !== want_data[i]) begin errors++; $display("FAIL conflict_wdata[%0d] got=%h want=%h", i, rf_wdata, want_data[i]); end
         checks++; if (rf_waddr !== want_rd[i] || rf_we !== 1'b1) begin errors++; $display("FAIL conflict_write[%0d] got=%b/%0d want=1/%0d", i, rf_we, rf_waddr, want_rd[i]); end
      end
      req_valid = 3'b000;
   endtask

   task automatic test_rd_zero;
      req_valid = 3'b010; set_src(1, 32'hDEAD_BEEF, 5'd0);
      tick();
      checks++; if (obs_ready !== 3'b010) begin errors++; $display("FAIL rd0_ready got=%b want=010", obs_ready); end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rd0_we got=%b want=0", rf_we); end
      checks++; if (rf_wdata !== 32'hDEAD_BEEF || rf_waddr !== 5'd0) begin errors++; $display("FAIL rd0_regs got=%0d/%h want=0/deadbeef", rf_waddr, rf_wdata); end
      req_valid = 3'b000;
   endtask

   task automatic test_idle;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      req_valid = 3'b111; set_src(2, 32'h5555_AAAA, 5'd17); set_src(0, 32'h1, 5'd1); set_src(1, 32'h2, 5'd2);
      tick();
      a = rf_waddr; d = rf_wdata;
      req_valid = 3'b000; set_src(0, 32'hFFFF_0000, 5'd30);
      tick();
      checks++; if (obs_ready !== 3'b000) begin errors++; $display("FAIL idle_ready got=%b want=000", obs_ready); end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_we got=%b want=0", rf_we); end
      checks++; if (rf_waddr !== a || rf_wdata !== d) begin errors++; $display("FAIL idle_hold got=%0d/%h want=%0d/%h", rf_waddr, rf_wdata, a, d); end
   endtask

   task automatic test_reset_mid;
      rst = 1'b1; tick(); rst = 1'b0;
      set_src(0, 32'h10, 5'd10); set_src(1, 32'h20, 5'd20); set_src(2, 32'h30, 5'd30);
      req_valid = 3'b111;
      tick(); tick();
      checks++; if (obs_ready !== 3'b010) begin errors++; $display("FAIL midrst_pre got=%b want=010", obs_ready); end
      rst = 1'b1;
      tick();
      checks++; if (obs_ready !== 3'b000) begin errors++; $display("FAIL midrst_ready got=%b want=000", obs_ready); end
      checks++; if (rf_we !== 1'b0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL midrst_write got=%b/%h want=0/0", rf_we, rf_wdata); end
      rst = 1'b0;
      tick();
      checks++; if (obs_ready !== 3'b001) begin errors++; $display("FAIL midrst_after got=%b want=001", obs_ready); end
      checks++; if (rf_wdata !== 32'h10 || rf_we !== 1'b1) begin errors++; $display("FAIL midrst_wdata got=%b/%h want=1/10", rf_we, rf_wdata); end
      req_valid = 3'b000;
   endtask

`ifdef WB_ARB_CONFLICT_CNT_EN
   task automatic test_counter;
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (conflict_cnt !== 4'd0) begin errors++; $display("FAIL cnt_reset got=%0d want=0", conflict_cnt); end
      req_valid = 3'b011;
      for (int c = 0; c < 10; c++) tick();
      checks++; if (conflict_cnt !== 4'd10) begin errors++; $display("FAIL cnt_10 got=%0d want=10", conflict_cnt); end
      for (int c = 0; c < 10; c++) tick();
      checks++; if (conflict_cnt !== 4'd15) begin errors++; $display("FAIL cnt_sat got=%0d want=15", conflict_cnt); end
      req_valid = 3'b000;
   endtask
`endif

   task automatic test_random;
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < 3; i++)
            if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
               set_src(i, $urandom, 5'($urandom_range(0, 31)));
               req_valid[i] = 1'b1;
            end
         tick();
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got=%b want=%b", c, obs_ready, exp_ready); end
         checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rand_we[%0d] got=%b want=%b", c, rf_we, m_we); end
         checks++; if (rf_waddr !== m_waddr) begin errors++; $display("FAIL rand_waddr[%0d] got=%0d want=%0d", c, rf_waddr, m_waddr); end
         checks++; if (rf_wdata !== m_wdata) begin errors++; $display("FAIL rand_wdata[%0d] got=%h want=%h", c, rf_wdata, m_wdata); end
`ifdef WB_ARB_CONFLICT_CNT_EN
         checks++; if (conflict_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d] got=%0d want=%0d", c, conflict_cnt, m_cnt); end
`endif
         if (grant_idx >= 0) req_valid[grant_idx] = 1'b0;
      end
      rst = 1'b0; req_valid = 3'b000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_conflict();
      test_rd_zero();
      test_idle();
      test_reset_mid();
`ifdef WB_ARB_CONFLICT_CNT_EN
      test_counter();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
